updi_phy_xcvr: RTL and testbench

UPDI_PHY_XCVR -- requirements
Module: updi_phy_xcvr

---
 rtl/updi_phy_xcvr.sv | 242 ++++++++++++++++++++++++
 tb/tb_updi_phy_xcvr.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_phy_xcvr.sv
// Half-duplex UPDI-style serial transceiver: frames memory words out on pwdata,
// and writes frames received on prdata back into the same single-port memory.
module updi_phy_xcvr #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ten,
  input  logic              ren,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] n_words,
  output logic              tend,
  output logic              rend,
  output logic              perr,
  output logic              ferr,
  output logic              busy,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              pwdata,
  input  logic              prdata,
  output logic [3:0]        o_dbg_state
);

  localparam int   BIT_W = $clog2(DATA_W + 1);
  localparam logic P_ODD = (PARITY_ODD != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_TSTART, S_TDATA, S_TPAR, S_TSTOP, S_DONE,
    S_RSTART, S_RDATA, S_RPAR, S_RSTOP, S_WRITE
  } state_t;

  state_t            r_state;
  logic              r_s1, r_s2, r_s3;
  logic [DIV_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic              r_stop;
  logic [ADDR_W-1:0] r_idx, r_nwords, r_addr;
  logic [DATA_W-1:0] r_sh, r_rsh, r_odata;
  logic              r_par, r_pw, r_csb, r_web, r_tend, r_rend;
  logic              r_perr, r_ferr, r_rx_act;

  logic [DIV_W-1:0]  w_div, w_half;
  logic              w_bit_end, w_sample, w_fall, w_last, w_last_bit, w_last_stop, w_rx_state;

  assign w_div       = (div < DIV_W'(3)) ? DIV_W'(3) : div;
  assign w_half      = w_div >> 1;
  assign w_bit_end   = (r_cnt == w_div);
  assign w_sample    = (r_cnt == w_half);
  assign w_fall      = r_s3 & ~r_s2;
  assign w_last      = (r_idx == r_nwords - ADDR_W'(1));
  assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
  assign w_last_stop = (r_stop == 1'(STOP_BITS - 1));
  assign w_rx_state  = (r_state inside {S_RSTART, S_RDATA, S_RPAR, S_RSTOP, S_WRITE});

  assign tend        = r_tend;
  assign rend        = r_rend;
  assign perr        = r_perr;
  assign ferr        = r_ferr;
  assign busy        = (r_state != S_IDLE);
  assign csb0        = r_csb;
  assign web0        = r_web;
  assign addr0       = r_addr;
  assign o_data      = r_odata;
  assign pwdata      = r_pw;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_s3     <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_idx    <= '0;
      r_nwords <= '0;
      r_addr   <= '0;
      r_sh     <= '0;
      r_rsh    <= '0;
      r_odata  <= '0;
      r_par    <= 1'b0;
      r_pw     <= 1'b1;
      r_csb    <= 1'b1;
      r_web    <= 1'b1;
      r_tend   <= 1'b0;
      r_rend   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_rx_act <= 1'b0;
    end else begin
      r_s1   <= prdata;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_tend <= 1'b0;
      r_rend <= 1'b0;
      r_cnt  <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!ren) r_rx_act <= 1'b0;
          if (ten) begin
            r_state  <= S_FETCH;
            r_idx    <= '0;
            r_addr   <= '0;
            r_nwords <= n_words;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_rx_act <= 1'b0;
            r_csb    <= (n_words == '0);
          end else if (ren && w_fall && (r_rx_act || n_words != '0)) begin
            r_state <= S_RSTART;
          end
        end
        S_FETCH: begin
          r_csb <= 1'b1;
          if (r_idx == r_nwords) begin
            r_state <= S_DONE;
            r_tend  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sh    <= i_data;
          r_par   <= (^i_data) ^ P_ODD;
          r_pw    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_TSTART;
        end
        S_TSTART: if (w_bit_end) begin
          r_pw    <= r_sh[0];
          r_sh    <= r_sh >> 1;
          r_bit   <= '0;
          r_state <= S_TDATA;
        end
        S_TDATA: if (w_bit_end) begin
          if (w_last_bit) begin
            r_pw    <= r_par;
            r_state <= S_TPAR;
          end else begin
            r_pw  <= r_sh[0];
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        S_TPAR: if (w_bit_end) begin
          r_pw    <= 1'b1;
          r_stop  <= 1'b0;
          r_state <= S_TSTOP;
        end
        S_TSTOP: if (w_bit_end) begin
          if (!w_last_stop) begin
            r_stop <= 1'b1;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_tend  <= 1'b1;
          end else begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_addr  <= r_idx + ADDR_W'(1);
            r_csb   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_RSTART: begin
          // A confirmed start bit of the first word is what opens a transfer.
          if (w_sample) begin
            if (r_s2) begin
              r_state <= S_IDLE;
            end else if (!r_rx_act) begin
              r_rx_act <= 1'b1;
              r_idx    <= '0;
              r_nwords <= n_words;
              r_perr   <= 1'b0;
              r_ferr   <= 1'b0;
            end
          end
          if (w_bit_end) begin
            r_bit   <= '0;
            r_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_sample) r_rsh <= {r_s2, r_rsh[DATA_W-1:1]};
          if (w_bit_end) begin
            if (w_last_bit) r_state <= S_RPAR;
            else            r_bit   <= r_bit + BIT_W'(1);
          end
        end
        S_RPAR: begin
          if (w_sample && (r_s2 != ((^r_rsh) ^ P_ODD))) r_perr <= 1'b1;
          if (w_bit_end) begin
            r_stop  <= 1'b0;
            r_state <= S_RSTOP;
          end
        end
        S_RSTOP: begin
          // Leave at the middle of the last stop bit so the next start edge is not missed.
          if (w_sample) begin
            if (!r_stop && !r_s2) r_ferr <= 1'b1;
            if (w_last_stop) begin
              r_csb   <= 1'b0;
              r_web   <= 1'b0;
              r_addr  <= r_idx;
              r_odata <= r_rsh;
              r_state <= S_WRITE;
            end
          end
          if (w_bit_end) r_stop <= 1'b1;
        end
        S_WRITE: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_state <= S_IDLE;
          if (w_last) begin
            r_rend   <= 1'b1;
            r_rx_act <= 1'b0;
          end else begin
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_rx_state && !ren) begin
        r_state  <= S_IDLE;
        r_rx_act <= 1'b0;
        r_csb    <= 1'b1;
        r_web    <= 1'b1;
        r_rend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updi_phy_xcvr.sv
// Bench for updi_phy_xcvr: memory model, serial line driver/decoder and
// queue-based scoreboards for transmitted frames and memory writes.
module tb_updi_phy_xcvr;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ten = 1'b0;
  logic              ren = 1'b0;
  logic              prdata = 1'b1;
  logic [DIV_W-1:0]  div = 16'd3;
  logic [ADDR_W-1:0] n_words = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic              tend, rend, perr, ferr, busy, csb0, web0, pwdata;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] o_data;
  logic [3:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:127];
  int checks = 0;
  int failures = 0;
  int tend_cnt = 0;
  int rend_cnt = 0;

  logic [11:0]             tx_exp_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
  logic [7:0] rx_b[$];
  bit         rx_pf[$];
  bit         rx_sf[$];

  localparam logic [31:0] RST_VEC = {9'd0, 1'b1, 1'b1, 1'b1, 7'd0, 8'd0, 5'd0};

  updi_phy_xcvr dut (
    .clk(clk), .rst(rst), .ten(ten), .ren(ren), .div(div), .n_words(n_words),
    .tend(tend), .rend(rend), .perr(perr), .ferr(ferr), .busy(busy),
    .csb0(csb0), .web0(web0), .addr0(addr0), .i_data(i_data), .o_data(o_data),
    .pwdata(pwdata), .prdata(prdata), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: read data valid one cycle after a read select
  always @(posedge clk) begin
    if (!csb0 && web0)  i_data <= mem[addr0];
    if (!csb0 && !web0) mem[addr0] <= o_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outvec();
    return {9'd0, pwdata, csb0, web0, addr0, o_data, tend, rend, perr, ferr, busy};
  endfunction

  function automatic int eff(input logic [DIV_W-1:0] d);
    return (d < 3) ? 3 : int'(d);
  endfunction

  // start 0, data LSB first, even parity, two stop bits
  function automatic logic [11:0] frame_of(input logic [7:0] b);
    return {2'b11, ^b, b, 1'b0};
  endfunction

  // monitor: pulse counters and memory writes
  always @(negedge clk) begin
    if (!rst) begin
      if (tend) tend_cnt++;
      if (rend) rend_cnt++;
      if (!csb0 && !web0) begin
        if (wr_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0h data=%0h required=none", addr0, o_data);
        end else begin
          check("mem_write", 32'({addr0, o_data}), 32'(wr_exp_q.pop_front()));
        end
      end
    end
  end

  // monitor: decode frames on pwdata by mid-bit sampling
  initial begin : tx_monitor
    logic       tx_prev;
    logic [11:0] fr;
    int         per;
    bit         aborted;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx_prev && !pwdata) begin
        per = eff(div) + 1;
        aborted = 0;
        fr = '0;
        for (int c = 0; c < per / 2 && !aborted; c++) begin
          @(negedge clk);
          if (rst) aborted = 1;
        end
        fr[0] = pwdata;
        for (int b = 1; b < 12 && !aborted; b++) begin
          for (int c = 0; c < per && !aborted; c++) begin
            @(negedge clk);
            if (rst) aborted = 1;
          end
          fr[b] = pwdata;
        end
        if (!aborted) begin
          if (tx_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx_frame actual=%0h required=none", fr);
          end else begin
            check("tx_frame", 32'(fr), 32'(tx_exp_q.pop_front()));
          end
        end
      end
      tx_prev = rst ? 1'b1 : pwdata;
    end
  end

  // driver tasks
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_timeout busy=1 after %0d cycles required=0", name, budget);
    end
  endtask

  task automatic tx_transfer(input string name, input int nw, input logic [DIV_W-1:0] d, input bit fill);
    int t0;
    div = d;
    n_words = ADDR_W'(nw);
    for (int i = 0; i < nw; i++) begin
      if (fill) mem[i] = 8'($urandom);
      tx_exp_q.push_back(frame_of(mem[i]));
    end
    t0 = tend_cnt;
    @(negedge clk) ten = 1'b1;
    @(negedge clk) ten = 1'b0;
    wait_idle(name, 100 * nw + 40);
    repeat (2) @(negedge clk);
    check({name, "_tend"}, tend_cnt - t0, 1);
    check({name, "_frames_left"}, tx_exp_q.size(), 0);
    check({name, "_line_idle"}, {31'd0, pwdata}, 1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pf, input bit sf, input int per);
    logic [11:0] bits;
    bits = {1'b1, ~sf, (^b) ^ pf, b, 1'b0};
    for (int i = 0; i < 12; i++) begin
      prdata = bits[i];
      repeat (per) @(negedge clk);
    end
    prdata = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  task automatic rx_transfer(input string name, input logic [DIV_W-1:0] d);
    int per, r0, nw;
    bit ep, ef;
    nw = rx_b.size();
    div = d;
    per = eff(d) + 1;
    n_words = ADDR_W'(nw);
    ren = 1'b1;
    r0 = rend_cnt;
    ep = 0;
    ef = 0;
    @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      wr_exp_q.push_back({ADDR_W'(w), rx_b[w]});
      ep |= rx_pf[w];
      ef |= rx_sf[w];
      send_frame(rx_b[w], rx_pf[w], rx_sf[w], per);
    end
    rx_b.delete();
    rx_pf.delete();
    rx_sf.delete();
    repeat (per + 4) @(negedge clk);
    check({name, "_rend"}, rend_cnt - r0, 1);
    check({name, "_perr"}, {31'd0, perr}, {31'd0, ep});
    check({name, "_ferr"}, {31'd0, ferr}, {31'd0, ef});
    check({name, "_writes_left"}, wr_exp_q.size(), 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin : stimulus
    int t0, r0, mx;
    for (int i = 0; i < 128; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", outvec(), RST_VEC);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", outvec(), RST_VEC);

    // V1 directed transmit of 0x55
    mem[0] = 8'h55;
    tx_transfer("v1_tx", 1, 16'd3, 0);

    // n_words=0 transmit: no memory access, tend two cycles after sampling
    n_words = '0;
    t0 = tend_cnt;
    @(negedge clk) ten = 1'b1;
    @(negedge clk) ten = 1'b0;
    check("nw0_tx_c1", {30'd0, tend, csb0}, 32'b01);
    @(negedge clk);
    check("nw0_tx_c2", {30'd0, tend, csb0}, 32'b11);
    @(negedge clk);
    check("nw0_tx_c3", {29'd0, tend, csb0, busy}, 32'b010);
    check("nw0_tx_count", tend_cnt - t0, 1);

    // V2 / V3 / V4 directed receives of 0xA3
    rx_b.push_back(8'hA3); rx_pf.push_back(0); rx_sf.push_back(0);
    rx_transfer("v2_rx", 16'd3);
    rx_b.push_back(8'hA3); rx_pf.push_back(1); rx_sf.push_back(0);
    rx_transfer("v3_rx_parity", 16'd3);
    rx_b.push_back(8'hA3); rx_pf.push_back(0); rx_sf.push_back(1);
    rx_transfer("v4_rx_frame", 16'd3);
    rx_b.push_back(8'h3C); rx_pf.push_back(0); rx_sf.push_back(0);
    rx_transfer("v4_rx_clear", 16'd3);

    // n_words=0 receive: block stays idle
    n_words = '0;
    ren = 1'b1;
    mx = 0;
    @(negedge clk) prdata = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 3) prdata = 1'b1;
      if (busy) mx = 1;
    end
    check("nw0_rx_busy", mx, 0);

    // V5 one-clock glitch
    n_words = ADDR_W'(1);
    r0 = rend_cnt;
    @(negedge clk) prdata = 1'b0;
    @(negedge clk) prdata = 1'b1;
    repeat (8) @(negedge clk);
    check("v5_glitch_busy", {31'd0, busy}, 0);
    check("v5_glitch_rend", rend_cnt - r0, 0);

    // ren dropped mid-frame
    n_words = ADDR_W'(2);
    r0 = rend_cnt;
    @(negedge clk) prdata = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 1);
    ren = 1'b0;
    @(negedge clk);
    check("abort_idle", {31'd0, busy}, 0);
    prdata = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_rend", rend_cnt - r0, 0);

    // V6 reset during DATA bit 3 of a 3-word transmit
    ren = 1'b1;
    div = 16'd3;
    n_words = ADDR_W'(3);
    mem[0] = 8'h81; mem[1] = 8'h42; mem[2] = 8'h24;
    tx_exp_q.push_back(frame_of(mem[0]));
    t0 = tend_cnt;
    @(negedge clk) ten = 1'b1;
    @(negedge clk) ten = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("v6_reset_outputs", outvec(), RST_VEC);
    tx_exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("v6_no_tend", tend_cnt - t0, 0);
    n_words = ADDR_W'(1);
    tx_exp_q.push_back(frame_of(mem[0]));
    t0 = tend_cnt;
    @(negedge clk) ten = 1'b1;
    @(negedge clk) ten = 1'b0;
    check("v6_restart_addr", {24'd0, csb0, addr0}, 32'h0);
    wait_idle("v6_restart", 100);
    repeat (2) @(negedge clk);
    check("v6_restart_tend", tend_cnt - t0, 1);
    check("v6_restart_frames", tx_exp_q.size(), 0);

    // randomized mix of transfers
    for (int it = 0; it < 10; it++) begin
      int nw;
      logic [DIV_W-1:0] d;
      nw = $urandom_range(1, 3);
      case ($urandom_range(0, 3))
        0:       d = 16'd1;
        1:       d = 16'd3;
        2:       d = 16'd4;
        default: d = 16'd5;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        ren = 1'($urandom_range(0, 1));
        tx_transfer("rand_tx", nw, d, 1);
      end else begin
        for (int w = 0; w < nw; w++) begin
          rx_b.push_back(8'($urandom));
          rx_pf.push_back($urandom_range(0, 3) == 0);
          rx_sf.push_back($urandom_range(0, 3) == 0);
        end
        rx_transfer("rand_rx", d);
      end
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
